// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//
// Staged reset-release controller placed directly after the reset
// synchronizer. After the synchronized system reset deasserts, the subsystem
// resets are released in a fixed order:
//   1. memory     (MEM_RST_) after a hold period,
//   2. reg file   (REG_RST_) once memory init reports ready, or on timeout,
//   3. CPU core   (CPU_RST_) a fixed gap after the register file.
// A synchronous warm-reset request (SOFT_RST_) puts every subsystem back into
// reset and restarts the hold period, without clearing the sticky timeout flag.
//
// Parameters
//   HOLD_CYCLES    (1..255) cycles all resets stay low after RST_ deasserts
//   STAGE_GAP      (1..255) cycles between REG_RST_ and CPU_RST_ release
//   MEM_TMO_CYCLES (1..255) longest wait for MEM_RDY before forcing release
//
// Ports
//   CLK        in   system clock, all state changes on posedge
//   RST_       in   asynchronous active-low reset (from synchronizer)
//   SOFT_RST_  in   synchronous active-low warm-reset request
//   MEM_RDY    in   memory initialisation complete (active high)
//   MEM_RST_   out  active-low reset to memory subsystem
//   REG_RST_   out  active-low reset to register file
//   CPU_RST_   out  active-low reset to CPU core
//   SEQ_DONE   out  high once fully released (RUN)
//   MEM_TMO    out  sticky: the memory-ready wait timed out
//
// Optional build macro RST_SEQ_DBG_EN adds:
//   SEQ_STATE  out [2:0] registered state encoding
//                        (ASSERT=0 HOLD=1 WAIT_MEM=2 REL_REG=3 RUN=4)
//   SOFT_CNT   out [7:0] accepted warm resets, saturating at 255
// ---------------------------------------------------------------------------
module rst_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGE_GAP      = 4,
  parameter int MEM_TMO_CYCLES = 200
) (
  input  logic       CLK,
  input  logic       RST_,
  input  logic       SOFT_RST_,
  input  logic       MEM_RDY,
  output logic       MEM_RST_,
  output logic       REG_RST_,
  output logic       CPU_RST_,
  output logic       SEQ_DONE,
  output logic       MEM_TMO
`ifdef RST_SEQ_DBG_EN
  ,
  output logic [2:0] SEQ_STATE,
  output logic [7:0] SOFT_CNT
`endif
);

  typedef enum logic [2:0] {
    S_ASSERT   = 3'd0,
    S_HOLD     = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_REL_REG  = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  // Counter reload values: a load of N-1 followed by the ==0 exit gives
  // exactly N edges spent in the stage.
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD  = 8'(STAGE_GAP - 1);
  localparam logic [7:0] TMO_LD  = 8'(MEM_TMO_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;

`ifdef RST_SEQ_DBG_EN
  // Set while a warm-reset request is being held so a multi-cycle request
  // counts as one accepted warm reset.
  logic       soft_held;
  logic [7:0] soft_cnt;
  assign SEQ_STATE = state;
  assign SOFT_CNT  = soft_cnt;
`endif

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state    <= S_ASSERT;
      cnt      <= 8'd0;
      MEM_RST_ <= 1'b0;
      REG_RST_ <= 1'b0;
      CPU_RST_ <= 1'b0;
      SEQ_DONE <= 1'b0;
      MEM_TMO  <= 1'b0;
`ifdef RST_SEQ_DBG_EN
      soft_held <= 1'b0;
      soft_cnt  <= 8'd0;
`endif
    end else begin
`ifdef RST_SEQ_DBG_EN
      soft_held <= 1'b0;
`endif
      case (state)
        S_ASSERT: begin
          // Warm reset is meaningless here: everything is already held.
          state    <= S_HOLD;
          cnt      <= HOLD_LD;
          MEM_RST_ <= 1'b0;
          REG_RST_ <= 1'b0;
          CPU_RST_ <= 1'b0;
          SEQ_DONE <= 1'b0;
        end

        S_HOLD, S_WAIT_MEM, S_REL_REG, S_RUN: begin
          if (!SOFT_RST_) begin
            // Warm reset outranks every other exit condition; holding it low
            // keeps reloading the counter so HOLD is stretched.
            state    <= S_HOLD;
            cnt      <= HOLD_LD;
            MEM_RST_ <= 1'b0;
            REG_RST_ <= 1'b0;
            CPU_RST_ <= 1'b0;
            SEQ_DONE <= 1'b0;
`ifdef RST_SEQ_DBG_EN
            soft_held <= 1'b1;
            if (!soft_held && soft_cnt != 8'hFF)
              soft_cnt <= soft_cnt + 8'd1;
`endif
          end else begin
            case (state)
              S_HOLD: begin
                if (cnt == 8'd0) begin
                  state    <= S_WAIT_MEM;
                  cnt      <= TMO_LD;
                  MEM_RST_ <= 1'b1;
                end else begin
                  cnt <= cnt - 8'd1;
                end
              end

              S_WAIT_MEM: begin
                // MEM_RDY is checked first so a ready on the timeout edge
                // does not raise the timeout flag.
                if (MEM_RDY) begin
                  state    <= S_REL_REG;
                  cnt      <= GAP_LD;
                  REG_RST_ <= 1'b1;
                end else if (cnt == 8'd0) begin
                  state    <= S_REL_REG;
                  cnt      <= GAP_LD;
                  REG_RST_ <= 1'b1;
                  MEM_TMO  <= 1'b1;
                end else begin
                  cnt <= cnt - 8'd1;
                end
              end

              S_REL_REG: begin
                if (cnt == 8'd0) begin
                  state    <= S_RUN;
                  CPU_RST_ <= 1'b1;
                  SEQ_DONE <= 1'b1;
                end else begin
                  cnt <= cnt - 8'd1;
                end
              end

              default: begin
                // RUN: terminal, resets stay released, MEM_RDY ignored.
                state <= S_RUN;
              end
            endcase
          end
        end

        default: begin
          // Corrupted state: fall back to the fully-held condition and let
          // the sequence restart from ASSERT.
          state    <= S_ASSERT;
          cnt      <= 8'd0;
          MEM_RST_ <= 1'b0;
          REG_RST_ <= 1'b0;
          CPU_RST_ <= 1'b0;
          SEQ_DONE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
//
// Drives directed scenarios (cold boot, memory timeout, warm reset, priority
// corners, asynchronous abort) followed by randomized traffic. Expected
// outputs come from a timestamp model: it records the edge at which the hold
// period last started and the edge at which the register file was released,
// and derives every output from those two numbers and the parameters.
// ---------------------------------------------------------------------------
module tb_rst_sequencer;

  localparam int H = 16;
  localparam int G = 4;
  localparam int T = 200;

  logic CLK = 1'b0;
  logic RST_, SOFT_RST_, MEM_RDY;
  logic MEM_RST_, REG_RST_, CPU_RST_, SEQ_DONE, MEM_TMO;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int e          = 0;   // count of edges seen
  bit started    = 0;   // an edge with RST_ high has occurred since reset
  int hold_start = 0;   // edge at which the current hold period began
  int reg_edge   = -1;  // edge at which REG_RST_ was released, -1 if not yet
  bit tmo        = 0;

  rst_sequencer #(
    .HOLD_CYCLES   (H),
    .STAGE_GAP     (G),
    .MEM_TMO_CYCLES(T)
  ) dut (
    .CLK      (CLK),
    .RST_     (RST_),
    .SOFT_RST_(SOFT_RST_),
    .MEM_RDY  (MEM_RDY),
    .MEM_RST_ (MEM_RST_),
    .REG_RST_ (REG_RST_),
    .CPU_RST_ (CPU_RST_),
    .SEQ_DONE (SEQ_DONE),
    .MEM_TMO  (MEM_TMO)
  );

  always #5 CLK = ~CLK;

  // Release order must hold at every edge, in every scenario.
  a_order: assert property (@(posedge CLK) (CPU_RST_ -> REG_RST_) && (REG_RST_ -> MEM_RST_))
    else begin
      miscompares++;
      $error("FAIL order: cpu=%b reg=%b mem=%b required cpu->reg->mem", CPU_RST_, REG_RST_, MEM_RST_);
    end

  function automatic logic [4:0] expv();
    logic m, r, c;
    m = started && (e >= hold_start + H);
    r = (reg_edge >= 0);
    c = r && (e >= reg_edge + G);
    return {m, r, c, c, tmo};
  endfunction

  task automatic check(input string tag);
    logic [4:0] got;
    logic [4:0] exp;
    got = {MEM_RST_, REG_RST_, CPU_RST_, SEQ_DONE, MEM_TMO};
    exp = expv();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s edge=%0d {mem,reg,cpu,done,tmo} got=%b expected=%b", tag, e, got, exp);
    end
  endtask

  // Model reaction to one clock edge with RST_ high.
  task automatic model_edge(input bit s, input bit r);
    e++;
    if (!started) begin
      started    = 1;
      hold_start = e;
      reg_edge   = -1;
    end else if (!s) begin
      hold_start = e;
      reg_edge   = -1;
    end else if (reg_edge < 0 && e > hold_start + H) begin
      if (r) reg_edge = e;
      else if (e == hold_start + H + T) begin
        reg_edge = e;
        tmo      = 1;
      end
    end
  endtask

  task automatic step(input bit s, input bit r, input string tag);
    SOFT_RST_ = s;
    MEM_RDY   = r;
    @(posedge CLK);
    model_edge(s, r);
    #1;
    check(tag);
  endtask

  task automatic steps(input int n, input bit s, input bit r, input string tag);
    for (int i = 0; i < n; i++) step(s, r, tag);
  endtask

  // Pull RST_ low between edges and confirm the outputs drop without a clock.
  task automatic abort(input int n);
    #3;
    RST_ = 1'b0;
    #1;
    started  = 0;
    tmo      = 0;
    reg_edge = -1;
    check("async_abort");
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      check("held_in_reset");
    end
    RST_ = 1'b1;
  endtask

  initial begin
    RST_      = 1'b1;
    SOFT_RST_ = 1'b1;
    MEM_RDY   = 1'b0;
    #2;
    RST_ = 1'b0;
    #1;
    check("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("reset_state");
    end
    RST_ = 1'b1;

    // Cold boot with memory ready immediately: mem@17, reg@18, cpu@22.
    steps(25, 1, 1, "cold_boot");

    // Warm reset from RUN, 5 cycles low, then full re-release.
    steps(5, 0, 1, "warm_low");
    steps(24, 1, 1, "warm_release");

    // Memory timeout, then warm reset must not clear the flag.
    abort(3);
    steps(H + T + G + 5, 1, 0, "mem_timeout");
    steps(5, 0, 0, "warm_after_tmo");
    steps(30, 1, 1, "tmo_sticky");

    // Warm reset ignored in ASSERT; then warm reset beats MEM_RDY in WAIT_MEM.
    abort(2);
    step(0, 0, "soft_in_assert");
    steps(16, 1, 0, "to_wait_mem");
    step(0, 1, "soft_beats_rdy");
    steps(25, 1, 1, "after_priority");

    // MEM_RDY arrives on the exact timeout edge: no timeout flag.
    abort(2);
    steps(17 + T - 1, 1, 0, "wait_full");
    step(1, 1, "rdy_on_tmo_edge");
    steps(6, 1, 0, "after_tie");

    // Asynchronous abort during REL_REG, then the whole sequence again.
    abort(2);
    steps(17, 1, 0, "to_wait_mem2");
    steps(2, 1, 1, "in_rel_reg");
    abort(3);
    steps(25, 1, 1, "rerun_after_abort");

    // Randomized traffic.
    for (int run = 0; run < 30; run++) begin
      int n;
      int rdy_odds;
      abort($urandom_range(1, 3));
      n        = $urandom_range(20, 300);
      rdy_odds = $urandom_range(1, 60);
      for (int i = 0; i < n; i++) begin
        bit s, r;
        s = ($urandom_range(0, 39) != 0);
        r = ($urandom_range(0, rdy_odds - 1) == 0);
        step(s, r, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Staged reset-release controller. Sits directly downstream of the reset synchronizer.
- Consumes the synchronized active-low system reset. Releases subsystem resets in a fixed order:
  - memory first,
  - then register file,
  - then CPU core (PC / control FSM).
- Holds the CPU in reset until memory initialization reports ready, or until a timeout expires.
- Also handles software-requested warm resets.

Parameters:
- HOLD_CYCLES, 16: cycles all resets stay asserted after RST_ deasserts. Legal range 1..255.
- STAGE_GAP, 4: cycles between REG_RST_ release and CPU_RST_ release. Legal range 1..255.
- MEM_TMO_CYCLES, 200: maximum cycles spent waiting for MEM_RDY. Legal range 1..255.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RST_  input  1  reset, asynchronous, active-low (driven by the synchronizer stage).
- SOFT_RST_  input  1  synchronous active-low warm-reset request, sampled on posedge.
- MEM_RDY  input  1  memory initialization complete, active high, synchronous.
- MEM_RST_  output  1  active-low reset to memory subsystem.
- REG_RST_  output  1  active-low reset to register file.
- CPU_RST_  output  1  active-low reset to CPU core.
- SEQ_DONE  output  1  high when fully released (state RUN).
- MEM_TMO  output  1  sticky flag: memory-ready wait timed out.

Behaviour:
- Registers and reset:
  - All outputs registered.
  - RST_ low asynchronously forces state=ASSERT, counter=0, and all outputs 0 (MEM_RST_=REG_RST_=CPU_RST_=0, SEQ_DONE=0, MEM_TMO=0).
  - RST_ low mid-sequence aborts the sequence immediately, with no clock edge required.
- Counter: 8 bits, down-counting.
- States and transitions (each transition happens on a CLK edge):
  - ASSERT: first edge with RST_ high → HOLD, counter loaded with HOLD_CYCLES-1.
  - HOLD: counter decrements each edge. On the edge where counter==0 → WAIT_MEM, MEM_RST_←1, counter loaded with MEM_TMO_CYCLES-1.
    - Timing: MEM_RST_ rises on edge HOLD_CYCLES+1, counting the first edge with RST_ high as edge 1.
  - WAIT_MEM: exits on whichever of these occurs first.
    - MEM_RDY=1 sampled → REL_REG, REG_RST_←1, counter loaded with STAGE_GAP-1.
    - Else, counter==0 → REL_REG, REG_RST_←1, MEM_TMO←1, counter loaded with STAGE_GAP-1.
    - Else, decrement counter.
    - MEM_RDY and timeout on the same edge: MEM_RDY wins, MEM_TMO is not set.
  - REL_REG: counter decrements. On the edge where counter==0 → RUN, CPU_RST_←1, SEQ_DONE←1.
    - CPU_RST_ rises STAGE_GAP edges after REG_RST_.
  - RUN: terminal state. All resets deasserted. MEM_RDY is ignored.
- Release-order invariant: MEM_RST_ rises no later than REG_RST_, which rises strictly before CPU_RST_. No output ever deasserts out of order.
- Warm reset (SOFT_RST_):
  - SOFT_RST_=0 sampled in HOLD, WAIT_MEM, REL_REG or RUN → next edge: MEM_RST_=REG_RST_=CPU_RST_=0, SEQ_DONE=0, state=HOLD, counter loaded with HOLD_CYCLES-1.
  - While SOFT_RST_ stays 0, the counter reloads every edge, so HOLD is extended. The sequence resumes on the first edge with SOFT_RST_=1.
  - SOFT_RST_ has priority over MEM_RDY, timeout, and counter expiry.
  - SOFT_RST_ is ignored in ASSERT.
  - MEM_TMO is NOT cleared by warm reset; only RST_ clears it.
- Default arm: any illegal state encoding → ASSERT outputs (all resets 0) on the next edge.

Optional Feature:
- Macro: RST_SEQ_DBG_EN.
- Defined: adds output port SEQ_STATE [2:0] carrying the registered state encoding (ASSERT=0, HOLD=1, WAIT_MEM=2, REL_REG=3, RUN=4), reset value 0.
  - Also adds output SOFT_CNT [7:0]: counts accepted warm resets, saturates at 255, cleared only by RST_.
- Not defined: neither port exists. Functional behaviour of all other ports is identical.

Test Plan (HOLD_CYCLES=16, STAGE_GAP=4, MEM_TMO_CYCLES=200):
- Cold boot: RST_ low 3 cycles then high; MEM_RDY tied 1 → MEM_RST_ rises on edge 17; REG_RST_ on edge 18; CPU_RST_ and SEQ_DONE on edge 22; MEM_TMO=0.
- Memory timeout: MEM_RDY held 0 → REG_RST_ rises 200 edges after MEM_RST_, with MEM_TMO=1; CPU_RST_ rises 4 edges later; MEM_TMO stays 1 in RUN.
- Warm reset: in RUN, SOFT_RST_ low for 5 cycles → all resets 0 on the next edge; MEM_RST_ rises 16 edges after SOFT_RST_ returns high; MEM_TMO is unchanged.
- Priority: MEM_RDY=1 and SOFT_RST_=0 on the same edge in WAIT_MEM → state HOLD, REG_RST_ remains 0. MEM_RDY rising on the exact timeout edge → MEM_TMO=0.
- Async abort: RST_ pulled low mid-edge during REL_REG → all outputs 0 before the next CLK edge. After RST_ releases, the full sequence repeats from edge 1.
- Ordering check: concurrent assertion over all runs that CPU_RST_=1 implies REG_RST_=1, and REG_RST_=1 implies MEM_RST_=1.
